// File: rtl/chunk_add_seq.sv
// Sequential wide adder: feeds one N-bit adder slice a chunk at a time, LSB chunk first.
// Optional signed-overflow output enabled by defining CHUNK_ADD_OVF_EN.
module chunk_add_seq #(
  parameter int unsigned W = 64,
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o,
  output logic         busy_o
`ifdef CHUNK_ADD_OVF_EN
  ,
  output logic         ovf_o
`endif
);

  localparam int unsigned K    = W / N;
  localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(K - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            creg_q, creg_d;
  logic            carry_q, carry_d;
`ifdef CHUNK_ADD_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic [N-1:0]    a_sl, b_sl;
  logic [N:0]      slice;

  // The single narrow adder slice shared by every chunk.
  always_comb begin
    a_sl  = a_q[idx_q*N +: N];
    b_sl  = b_q[idx_q*N +: N];
    slice = {1'b0, a_sl} + {1'b0, b_sl} + {{N{1'b0}}, creg_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    creg_d  = creg_q;
    carry_d = carry_q;
`ifdef CHUNK_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          creg_d  = cin_i;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q*N +: N] = slice[N-1:0];
        creg_d              = slice[N];
        idx_d               = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          carry_d = slice[N];
`ifdef CHUNK_ADD_OVF_EN
          // On the top chunk slice[N-1] is the sign bit of the full sum.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice[N-1] != a_q[W-1]);
`endif
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      creg_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef CHUNK_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      creg_q  <= creg_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef CHUNK_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand registers only load on accept, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StRun) || (state_q == StDone);
  assign sum_o       = sum_q;
  assign carry_o     = carry_q;
`ifdef CHUNK_ADD_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule
